// File: rtl/neuro_resource_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// neuro_sched_pkg
// Shared types and constants for the neurotransmitter resource scheduler:
//   - sched_state_e : scheduler FSM states (INIT / RUN / PAUSE)
//   - NCH_DEFAULT   : default number of resource channels
//   - CH_*          : channel index of each neurotransmitter resource
//   - id_width()    : width of a channel index for a given channel count
// Optional feature macro used by the scheduler: SCHED_FAST_PRIORITY_EN
// -----------------------------------------------------------------------------
package neuro_sched_pkg;

    localparam int NCH_DEFAULT       = 4;

    localparam int CH_DOPAMINE       = 0;
    localparam int CH_SEROTONIN      = 1;
    localparam int CH_NOREPINEPHRINE = 2;
    localparam int CH_CORTISOL       = 3;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sched_state_e;

    // A single channel still needs a 1-bit index so vectors never collapse to 0 width.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : neuro_sched_pkg

// File: rtl/neuro_resource_scheduler_if.sv
// -----------------------------------------------------------------------------
// neuro_resource_scheduler_if
// Bundles the regulator-side requests and the resource-side strobes of the
// scheduler.
//   master modport (regulators/test side): drives enable, reinit, divider,
//       req_inc, req_dec, req_fast; observes inc, dec, fast, setval,
//       grant_id, slot.
//   slave modport (scheduler): the opposite directions.
// Parameters: NCH (channel count), DIV_W (slot divider width).
// -----------------------------------------------------------------------------
interface neuro_resource_scheduler_if #(
    parameter int NCH   = 4,
    parameter int DIV_W = 8
) ();
    import neuro_sched_pkg::*;

    localparam int ID_W = id_width(NCH);

    logic             enable;
    logic             reinit;
    logic [DIV_W-1:0] divider;
    logic [NCH-1:0]   req_inc;
    logic [NCH-1:0]   req_dec;
    logic [NCH-1:0]   req_fast;
    logic [NCH-1:0]   inc;
    logic [NCH-1:0]   dec;
    logic [NCH-1:0]   fast;
    logic [NCH-1:0]   setval;
    logic [ID_W-1:0]  grant_id;
    logic             slot;

    modport master (
        output enable, reinit, divider, req_inc, req_dec, req_fast,
        input  inc, dec, fast, setval, grant_id, slot
    );

    modport slave (
        input  enable, reinit, divider, req_inc, req_dec, req_fast,
        output inc, dec, fast, setval, grant_id, slot
    );

endinterface : neuro_resource_scheduler_if

// File: rtl/neuro_resource_scheduler_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin find-first: scans i_mask starting at i_ptr and
// wrapping modulo NCH; the first set bit wins.
// Ports:
//   i_mask  [NCH]  : eligible channels
//   i_ptr   [ID_W] : channel where the search starts
//   o_found        : at least one channel eligible
//   o_idx   [ID_W] : winning channel (0 when nothing found)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NCH  = 4,
    parameter int ID_W = 2
) (
    input  logic [NCH-1:0]  i_mask,
    input  logic [ID_W-1:0] i_ptr,
    output logic            o_found,
    output logic [ID_W-1:0] o_idx
);

    logic [ID_W-1:0] w_pos;

    // Scan from the farthest offset back to offset 0 so the nearest hit to the pointer is the last write.
    always_comb begin
        o_found = 1'b0;
        o_idx   = {ID_W{1'b0}};
        w_pos   = {ID_W{1'b0}};
        for (int k = NCH - 1; k >= 0; k--) begin
            w_pos = ID_W'((int'(i_ptr) + k) % NCH);
            if (i_mask[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end else begin
                o_found = o_found;
            end
        end
    end

endmodule : rr_picker

// File: rtl/neuro_resource_scheduler.sv
// -----------------------------------------------------------------------------
// neuro_resource_scheduler
// Time-multiplexed update scheduler for the neurotransmitter resource
// counters. Every divider+1 cycles (a "slot") at most one channel's
// inc/dec request is forwarded as a one-cycle strobe, chosen round-robin.
// After reset, or on reinit, a one-cycle setval load is sent to every
// resource.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : neuro_resource_scheduler_if.slave
//                in : enable, reinit, divider, req_inc, req_dec, req_fast
//                out: inc, dec, fast, setval, grant_id, slot (all registered)
// Optional feature: `define SCHED_FAST_PRIORITY_EN to restrict arbitration
// to fast-requesting channels whenever any valid channel requests fast.
// -----------------------------------------------------------------------------
module neuro_resource_scheduler
    import neuro_sched_pkg::*;
#(
    parameter int NCH   = NCH_DEFAULT,
    parameter int DIV_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    neuro_resource_scheduler_if.slave   bus
);

    localparam int              ID_W    = id_width(NCH);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NCH - 1);

    sched_state_e     r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_grant_id;
    logic [NCH-1:0]   r_inc;
    logic [NCH-1:0]   r_dec;
    logic [NCH-1:0]   r_fast;
    logic [NCH-1:0]   r_setval;
    logic             r_slot;

    logic [NCH-1:0]   w_valid;
    logic [NCH-1:0]   w_elig;
    logic             w_found;
    logic [ID_W-1:0]  w_idx;
    logic [ID_W-1:0]  w_next_ptr;
    logic [NCH-1:0]   w_win_oh;

    // inc and dec together cancel out, so only an exclusive request is valid.
    assign w_valid = bus.req_inc ^ bus.req_dec;

`ifdef SCHED_FAST_PRIORITY_EN
    logic [NCH-1:0] w_fast_valid;
    assign w_fast_valid = w_valid & bus.req_fast;

    // Fast requesters, when present, shut slow ones out of this slot.
    always_comb begin
        if (|w_fast_valid) begin
            w_elig = w_fast_valid;
        end else begin
            w_elig = w_valid;
        end
    end
`else
    assign w_elig = w_valid;
`endif

    rr_picker #(
        .NCH  (NCH),
        .ID_W (ID_W)
    ) u_rr_picker (
        .i_mask  (w_elig),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    // Pointer moves one past the winner, wrapping at the last channel.
    always_comb begin
        if (w_idx == LAST_ID) begin
            w_next_ptr = {ID_W{1'b0}};
        end else begin
            w_next_ptr = w_idx + ID_W'(1);
        end
    end

    // One-hot of the winning channel.
    always_comb begin
        w_win_oh        = {NCH{1'b0}};
        w_win_oh[w_idx] = 1'b1;
    end

    // Scheduler FSM: slot divider, arbitration and all registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_cnt      <= {DIV_W{1'b0}};
            r_ptr      <= {ID_W{1'b0}};
            r_grant_id <= {ID_W{1'b0}};
            r_inc      <= {NCH{1'b0}};
            r_dec      <= {NCH{1'b0}};
            r_fast     <= {NCH{1'b0}};
            r_setval   <= {NCH{1'b0}};
            r_slot     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_inc    <= {NCH{1'b0}};
            r_dec    <= {NCH{1'b0}};
            r_fast   <= {NCH{1'b0}};
            r_setval <= {NCH{1'b0}};
            r_slot   <= 1'b0;

            // reinit performs the INIT load on this very edge, so it also
            // overrides a slot event that was due in the same cycle.
            if (bus.reinit || (r_state == ST_INIT)) begin
                r_setval <= {NCH{1'b1}};
                r_cnt    <= bus.divider;
                r_ptr    <= {ID_W{1'b0}};
                r_state  <= bus.enable ? ST_RUN : ST_PAUSE;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (r_cnt != {DIV_W{1'b0}}) begin
                            r_cnt <= r_cnt - DIV_W'(1);
                        end else begin
                            // divider is only sampled here, so mid-period changes wait for the next reload.
                            r_cnt  <= bus.divider;
                            r_slot <= 1'b1;
                            if (w_found) begin
                                r_inc      <= w_win_oh & {NCH{bus.req_inc[w_idx]}};
                                r_dec      <= w_win_oh & {NCH{bus.req_dec[w_idx]}};
                                r_fast     <= w_win_oh & {NCH{bus.req_fast[w_idx]}};
                                r_grant_id <= w_idx;
                                r_ptr      <= w_next_ptr;
                            end else begin
                                r_ptr      <= r_ptr;
                            end
                        end
                        r_state <= bus.enable ? ST_RUN : ST_PAUSE;
                    end
                    ST_PAUSE: begin
                        // Counter is left untouched so the period resumes where it stopped.
                        r_state <= bus.enable ? ST_RUN : ST_PAUSE;
                    end
                    default: begin
                        r_state <= ST_INIT;
                    end
                endcase
            end
        end
    end

    assign bus.inc      = r_inc;
    assign bus.dec      = r_dec;
    assign bus.fast     = r_fast;
    assign bus.setval   = r_setval;
    assign bus.grant_id = r_grant_id;
    assign bus.slot     = r_slot;

endmodule : neuro_resource_scheduler

// File: tb/tb_neuro_resource_scheduler.sv
// -----------------------------------------------------------------------------
// tb_neuro_resource_scheduler
// Directed self-checking bench for neuro_resource_scheduler (NCH=4, DIV_W=8).
// Cycle n is the clock period following the n-th rising edge after reset
// release; outputs are sampled 1 time unit after each rising edge.
// Expected values follow SCHED_FAST_PRIORITY_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_neuro_resource_scheduler;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    neuro_resource_scheduler_if #(.NCH(4), .DIV_W(8)) bus_if ();

    neuro_resource_scheduler #(.NCH(4), .DIV_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic [3:0] e_inc, input logic [3:0] e_dec,
                           input logic [3:0] e_fast, input logic [3:0] e_setval,
                           input logic e_slot, input logic [1:0] e_gid);
        chk({tag, ".inc"},      32'(bus_if.inc),      32'(e_inc));
        chk({tag, ".dec"},      32'(bus_if.dec),      32'(e_dec));
        chk({tag, ".fast"},     32'(bus_if.fast),     32'(e_fast));
        chk({tag, ".setval"},   32'(bus_if.setval),   32'(e_setval));
        chk({tag, ".slot"},     32'(bus_if.slot),     32'(e_slot));
        chk({tag, ".grant_id"}, 32'(bus_if.grant_id), 32'(e_gid));
    endtask

    initial begin
        logic [3:0] e_oh;
        n_tests         = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus_if.enable   = 1'b1;
        bus_if.reinit   = 1'b0;
        bus_if.divider  = 8'd3;
        bus_if.req_inc  = 4'b0000;
        bus_if.req_dec  = 4'b0000;
        bus_if.req_fast = 4'b0000;

        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        rst_n = 1'b1;

        // Cycle 1: setval for one cycle; slots at 5 and 9 with divider 3.
        step();
        chk_all("init", 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 2'd0);
        for (int c = 2; c <= 12; c++) begin
            step();
            chk("period.slot", 32'(bus_if.slot), 32'((c == 5) || (c == 9)));
            chk("period.setval", 32'(bus_if.setval), 32'h0);
        end

        // Cycle 12 is a slot event: switch to a slot every cycle, all channels requesting inc.
        bus_if.divider = 8'd0;
        bus_if.req_inc = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            e_oh = 4'b0001 << (k % 4);
            chk_all("rotate", e_oh, 4'h0, 4'h0, 4'h0, 1'b1, 2'(k % 4));
        end

        // Pointer is now 2, last grant 1; conflicting request on channel 2 only.
        bus_if.req_inc = 4'b0100;
        bus_if.req_dec = 4'b0100;
        step();
        chk_all("conflict", 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 2'd1);

        bus_if.req_inc = 4'b1111;
        bus_if.req_dec = 4'b0000;
        step();
        chk_all("ptr_kept", 4'b0100, 4'h0, 4'h0, 4'h0, 1'b1, 2'd2);

        bus_if.req_inc  = 4'b0000;
        bus_if.req_dec  = 4'b1000;
        bus_if.req_fast = 4'b1000;
        step();
        chk_all("dec_fast", 4'h0, 4'b1000, 4'b1000, 4'h0, 1'b1, 2'd3);

        // Last every-cycle slot reloads with 3; cycle 22 idle slot, cycle 23 counter=2.
        bus_if.divider  = 8'd3;
        bus_if.req_dec  = 4'b0000;
        bus_if.req_fast = 4'b0000;
        step();
        chk_all("idle_slot", 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 2'd3);
        step();
        chk_all("count", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3);

        bus_if.enable  = 1'b0;
        bus_if.req_inc = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            step();
            chk_all("pause", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3);
        end

        bus_if.enable = 1'b1;
        step();
        chk("resume1.slot", 32'(bus_if.slot), 32'h0);
        step();
        chk("resume2.slot", 32'(bus_if.slot), 32'h0);
        step();
        chk_all("resume3", 4'b0001, 4'h0, 4'h0, 4'h0, 1'b1, 2'd0);

        // Counter 3,2,1,0: the third step lands in the slot-event cycle.
        for (int c = 0; c < 3; c++) begin
            step();
            chk("pre_reinit.slot", 32'(bus_if.slot), 32'h0);
        end
        bus_if.reinit = 1'b1;
        step();
        bus_if.reinit = 1'b0;
        chk_all("reinit", 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 2'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk_all("post_reinit", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
        end
        step();
        chk_all("reinit_ptr0", 4'b0001, 4'h0, 4'h0, 4'h0, 1'b1, 2'd0);

        // Reinit with divider 0 so the first RUN cycle is already a slot event, pointer 0.
        bus_if.reinit  = 1'b1;
        bus_if.divider = 8'd0;
        step();
        bus_if.reinit = 1'b0;
        chk_all("reinit2", 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 2'd0);
        bus_if.req_inc  = 4'b0011;
        bus_if.req_fast = 4'b0010;
        step();
`ifdef SCHED_FAST_PRIORITY_EN
        chk_all("fast_prio", 4'b0010, 4'h0, 4'b0010, 4'h0, 1'b1, 2'd1);
`else
        chk_all("fast_prio", 4'b0001, 4'h0, 4'h0, 4'h0, 1'b1, 2'd0);
`endif

        // Asynchronous reset in the middle of a strobe cycle.
        bus_if.req_inc = 4'b1111;
        step();
        rst_n = 1'b0;
        #1;
        chk_all("mid_reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);

        #20;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_neuro_resource_scheduler

// File: doc/neuro_resource_scheduler.md
# neuro_resource_scheduler

Time-multiplexed update scheduler for the neurotransmitter `resource` counters (dopamine, serotonin, norepinephrine, cortisol). Each regulator raises level requests (inc/dec/fast). The scheduler forwards at most one channel's request per update slot, as single-cycle strobes. Slots are paced by a programmable divider, and channels are picked round-robin. It also sequences the initial `setval` load of every resource after reset or on request. It sits between the regulators and the resource instances.

## Interface
Parameters:
- `NCH`, default 4: number of resource channels.
- `DIV_W`, default 8: width of the slot divider.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: scheduler runs while high; pauses while low.
- `reinit` in 1: single-cycle pulse; re-runs the setval sequence.
- `divider` in DIV_W: slot period minus one, in cycles.
- `req_inc` in NCH: per-channel increment request (level).
- `req_dec` in NCH: per-channel decrement request (level).
- `req_fast` in NCH: per-channel fast-step qualifier (level).
- `inc` out NCH: registered increment strobe, one-hot or zero.
- `dec` out NCH: registered decrement strobe, one-hot or zero.
- `fast` out NCH: registered fast strobe; only ever set alongside `inc` or `dec` of the same channel.
- `setval` out NCH: registered load strobe to all resources.
- `grant_id` out $clog2(NCH): index of the last granted channel.
- `slot` out 1: pulse on every slot boundary, granted or not.

## Operation
- States: INIT, RUN, PAUSE.
- INIT:
  - `setval` = all ones for exactly one cycle.
  - Counter is loaded with `divider`; pointer is cleared to 0.
  - Next state is RUN if `enable`, else PAUSE.
- RUN:
  - If counter ≠ 0: decrement.
  - If counter = 0: slot event. Counter reloads from the current `divider` (sampled at reload only), `slot` pulses, and arbitration runs.
  - `enable` low moves to PAUSE.
- PAUSE:
  - Counter holds its value; no strobes.
  - `enable` high returns to RUN and resumes the count where it stopped.
- Valid request for channel i: `req_inc[i]` XOR `req_dec[i]`. Both high counts as no request (conflict cancels).
- Arbitration:
  - Search starts at the pointer and wraps modulo NCH. The first valid channel wins.
  - The winner's `inc` or `dec` is asserted; `fast` is asserted if `req_fast` is high for it.
  - `grant_id` takes the winner's index; the pointer becomes winner+1 mod NCH.
  - With no valid channel: `slot` still pulses, no strobes, and the pointer and `grant_id` are unchanged.
- `reinit` goes to INIT from any state.
  - This includes a cycle where a slot event is due. `reinit` wins and no grant is issued.
- An asserted reset mid-operation clears everything immediately. No strobe survives reset.

## Timing
- Reset values:
  - state INIT, counter 0, pointer 0.
  - `inc`, `dec`, `fast`, `setval`, `slot` all 0; `grant_id` 0.
- The first rising edge after reset release registers `setval`, which is visible for cycle 1.
- A slot event occurs when counter = 0 in RUN. Strobes and `slot` appear on the following cycle and last exactly one cycle.
- Slot period is `divider`+1 cycles. With `divider`=0, there is a slot every cycle.
- Requests are sampled in the slot-event cycle only. Request changes between slots are ignored.
- `enable` and `reinit` take effect at the next edge.

## Configuration
`SCHED_FAST_PRIORITY_EN` controls fast-request priority.
- Defined: if any valid channel has `req_fast` high, only valid fast channels are eligible. Round-robin still applies among them from the pointer.
- Undefined: `req_fast` only qualifies the `fast` output and has no effect on arbitration.

## Structure
- Package `neuro_sched_pkg` holds:
  - the state enum (INIT/RUN/PAUSE);
  - the default NCH;
  - channel index constants CH_DOPAMINE=0, CH_SEROTONIN=1, CH_NOREPINEPHRINE=2, CH_CORTISOL=3.
- Sub-module `rr_picker` is a combinational find-first from pointer with wrap. Inputs are an eligible mask and a pointer; outputs are a found flag and an index.

## Test plan
- Reset release with `enable`=1, `divider`=3 → `setval`=4'b1111 in cycle 1 only; first `slot` at cycle 5, then every 4 cycles.
- `req_inc`=4'b1111 held, `divider`=0 → `inc` rotates 0001, 0010, 0100, 1000, 0001; `grant_id` follows 0,1,2,3,0.
- `req_inc[2]`=1 and `req_dec[2]`=1, nothing else → `slot` pulses with no strobes; pointer and `grant_id` unchanged.
- `enable` dropped with counter=2, held low 10 cycles, then raised → `slot` fires 3 cycles after re-enable; no strobes while paused.
- `reinit` pulsed in the slot-event cycle → no grant; `setval`=4'b1111 next cycle; pointer 0.
- `SCHED_FAST_PRIORITY_EN` defined, `req_inc`=4'b0011, `req_fast`=4'b0010, pointer 0 → `inc`=0010 and `fast`=0010. Same stimulus with the macro undefined → `inc`=0001, `fast`=0000.
